// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one LANES-wide DRAM byte-lane port between the fetch
// unit (requester 0) and the aggregate serializer (requester 1), with a grant watchdog.
module dram_port_arbiter #(
    parameter int LANES          = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LANES-1:0]      r0_en,
    input  logic                  r0_rdwr,
    input  logic [LANES*64-1:0]   r0_addr,
    input  logic [LANES*8-1:0]    r0_wdata,
    output logic [LANES-1:0]      r0_valid,
    output logic [LANES*8-1:0]    r0_rdata,
    input  logic [LANES-1:0]      r1_en,
    input  logic                  r1_rdwr,
    input  logic [LANES*64-1:0]   r1_addr,
    input  logic [LANES*8-1:0]    r1_wdata,
    output logic [LANES-1:0]      r1_valid,
    output logic [LANES*8-1:0]    r1_rdata,
    output logic [LANES-1:0]      dram_en,
    output logic                  dram_rdwr,
    output logic [LANES*64-1:0]   dram_addr,
    output logic [LANES*8-1:0]    dram_wdata,
    input  logic [LANES-1:0]      dram_valid,
    input  logic [LANES*8-1:0]    dram_rdata,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, RELEASE} state_t;

    state_t           state, state_next;
    logic [LANES-1:0] lane_mask, lane_mask_next;
    logic [LANES-1:0] done_mask, done_mask_next;
    logic             last_grant, last_grant_next;
    logic [CW-1:0]    wd, wd_next;

    logic             pend0, pend1, win0, win1;
    logic             in_grant, complete, fire;
    logic [LANES-1:0] hit;

    assign pend0    = |r0_en;
    assign pend1    = |r1_en;
    // On a tie the requester that did not hold the port last time wins.
    assign win0     = pend0 && (!pend1 || last_grant);
    assign win1     = pend1 && (!pend0 || !last_grant);
    assign in_grant = (state == GRANT0) || (state == GRANT1);
    assign hit      = dram_valid & lane_mask;
    assign complete = (done_mask | hit) == lane_mask;
    assign fire     = (wd == CW'(TIMEOUT_CYCLES - 1)) && !complete;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lane_mask  <= '0;
            done_mask  <= '0;
            last_grant <= 1'b1;
            wd         <= '0;
        end else begin
            state      <= state_next;
            lane_mask  <= lane_mask_next;
            done_mask  <= done_mask_next;
            last_grant <= last_grant_next;
            wd         <= wd_next;
        end
    end

    always_comb begin
        state_next      = state;
        lane_mask_next  = lane_mask;
        done_mask_next  = done_mask;
        last_grant_next = last_grant;
        wd_next         = wd;
        case (state)
            IDLE, RELEASE: begin
                if (win0) begin
                    state_next      = GRANT0;
                    lane_mask_next  = r0_en;
                    done_mask_next  = '0;
                    wd_next         = '0;
                    last_grant_next = 1'b0;
                end else if (win1) begin
                    state_next      = GRANT1;
                    lane_mask_next  = r1_en;
                    done_mask_next  = '0;
                    wd_next         = '0;
                    last_grant_next = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            GRANT0, GRANT1: begin
                done_mask_next = done_mask | hit;
                wd_next        = wd + 1'b1;
                // Completion takes priority over the watchdog in the same cycle.
                if (complete || fire) begin
                    state_next = RELEASE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dram_en     = '0;
        dram_rdwr   = 1'b0;
        dram_addr   = '0;
        dram_wdata  = '0;
        r0_valid    = '0;
        r0_rdata    = '0;
        r1_valid    = '0;
        r1_rdata    = '0;
        busy        = in_grant;
        grant       = {state == GRANT1, state == GRANT0};
        timeout_err = in_grant && fire;
        if (state == GRANT0) begin
            dram_en    = r0_en & lane_mask;
            dram_rdwr  = r0_rdwr;
            dram_addr  = r0_addr;
            dram_wdata = r0_wdata;
            r0_valid   = hit;
            r0_rdata   = dram_rdata;
        end else if (state == GRANT1) begin
            dram_en    = r1_en & lane_mask;
            dram_rdwr  = r1_rdwr;
            dram_addr  = r1_addr;
            dram_wdata = r1_wdata;
            r1_valid   = hit;
            r1_rdata   = dram_rdata;
        end
    end

endmodule
